// File: rtl/gpio_mulpop_pkg.sv
// Shared definitions for gpio_mulpop: FSM states, register offsets and STATUS bit positions.
package gpio_mulpop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] OFF_A1      = 16'h0000;
  localparam logic [15:0] OFF_A2      = 16'h0008;
  localparam logic [15:0] OFF_W_LO    = 16'h0010;
  localparam logic [15:0] OFF_L       = 16'h0018;
  localparam logic [15:0] OFF_STATUS  = 16'h0020;
  localparam logic [15:0] OFF_W_HI    = 16'h0028;
  localparam logic [15:0] OFF_OPCNT   = 16'h0030;
  localparam logic [15:0] OFF_GPIO_IN = 16'h0038;
  localparam logic [15:0] OFF_IRQ_CTL = 16'h0040;

  localparam int STAT_VALID = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_BUSY  = 2;

endpackage

// File: rtl/gpio_mulpop_core.sv
// Sequential shift-add multiplier (one multiplier bit per cycle, LSB first) followed by a
// one-cycle popcount of the full product; a start pulse always (re)starts the engine.
module gpio_mulpop_core
  import gpio_mulpop_pkg::*;
#(
  parameter int OP_W  = 24,
  parameter int RES_W = 2 * OP_W
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             i_start,
  input  logic [OP_W-1:0]  i_a,
  input  logic [OP_W-1:0]  i_b,
  output logic             o_busy,
  output logic             o_commit,
  output logic [RES_W-1:0] o_prod,
  output logic [6:0]       o_pop
);

  localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [RES_W-1:0]   r_mcand;
  logic [OP_W-1:0]    r_mplier;
  logic [RES_W-1:0]   r_acc;
  logic [6:0]         r_pop;

  function automatic logic [6:0] popcount(input logic [RES_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < RES_W; i++) n = n + {6'b0, v[i]};
    return n;
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_start)                r_cnt <= '0;
      else if (r_state == ST_MULT) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start) begin
      w_state_nxt = ST_MULT;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_MULT:  if (r_cnt == CNT_W'(OP_W - 1)) w_state_nxt = ST_COUNT;
        ST_COUNT: w_state_nxt = ST_DONE;
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: working registers carry no reset, the FSM qualifies their use
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_mcand  <= RES_W'(i_a);
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_state == ST_MULT) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
    if (r_state == ST_COUNT) r_pop <= popcount(r_acc);
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_commit = (r_state == ST_DONE) && !i_start;
  assign o_prod   = r_acc;
  assign o_pop    = r_pop;

endmodule

// File: rtl/gpio_mulpop.sv
// Bus-mapped multiply/popcount peripheral: register decode, strobe edge detect, GPIO capture.
// Optional interrupt (irq port and IRQ_CTL register) is built when GPIOEMU_IRQ_EN is defined.
module gpio_mulpop
  import gpio_mulpop_pkg::*;
#(
  parameter int          OP_W      = 24,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
`ifdef GPIOEMU_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int RES_W = 2 * OP_W;

  localparam logic [15:0] ADDR_A1      = BASE_ADDR + OFF_A1;
  localparam logic [15:0] ADDR_A2      = BASE_ADDR + OFF_A2;
  localparam logic [15:0] ADDR_W_LO    = BASE_ADDR + OFF_W_LO;
  localparam logic [15:0] ADDR_L       = BASE_ADDR + OFF_L;
  localparam logic [15:0] ADDR_STATUS  = BASE_ADDR + OFF_STATUS;
  localparam logic [15:0] ADDR_W_HI    = BASE_ADDR + OFF_W_HI;
  localparam logic [15:0] ADDR_OPCNT   = BASE_ADDR + OFF_OPCNT;
  localparam logic [15:0] ADDR_GPIO_IN = BASE_ADDR + OFF_GPIO_IN;
  localparam logic [15:0] ADDR_IRQ_CTL = BASE_ADDR + OFF_IRQ_CTL;

  logic             r_srd_d;
  logic             r_swr_d;
  logic             w_rd_e;
  logic             w_wr_e;
  logic             w_start;
  logic [OP_W-1:0]  r_a1;
  logic [63:0]      r_w;
  logic [6:0]       r_l;
  logic             r_done;
  logic [15:0]      r_opcnt;
  logic [31:0]      r_gpio_in_s;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_data;
  logic             w_busy;
  logic             w_commit;
  logic [RES_W-1:0] w_prod;
  logic [6:0]       w_pop;
  logic             w_done_clr;
  logic             w_unused;

  assign w_rd_e  = srd & ~r_srd_d;
  assign w_wr_e  = swr & ~r_swr_d;
  assign w_start = w_wr_e && (saddress == ADDR_A2);

  gpio_mulpop_core #(
    .OP_W  (OP_W),
    .RES_W (RES_W)
  ) u_core (
    .clk      (clk),
    .n_reset  (n_reset),
    .i_start  (w_start),
    .i_a      (r_a1),
    .i_b      (sdata_in[OP_W-1:0]),
    .o_busy   (w_busy),
    .o_commit (w_commit),
    .o_prod   (w_prod),
    .o_pop    (w_pop)
  );

`ifdef GPIOEMU_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  assign w_done_clr = w_wr_e && (saddress == ADDR_IRQ_CTL) && sdata_in[1];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_e && (saddress == ADDR_IRQ_CTL)) r_irq_en <= sdata_in[0];
      r_irq <= r_done & r_irq_en;
    end
  end

  assign irq = r_irq;
`else
  assign w_done_clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_srd_d     <= 1'b0;
      r_swr_d     <= 1'b0;
      r_a1        <= '0;
      r_w         <= '0;
      r_l         <= '0;
      r_done      <= 1'b0;
      r_opcnt     <= '0;
      r_gpio_in_s <= '0;
      sdata_out   <= '0;
    end else begin
      r_srd_d <= srd;
      r_swr_d <= swr;
      if (w_wr_e && (saddress == ADDR_A1)) r_a1 <= sdata_in[OP_W-1:0];
      // Start wins over commit, so an aborted op never updates results or the count
      if (w_start) begin
        r_done <= 1'b0;
      end else if (w_commit) begin
        r_w     <= 64'(w_prod);
        r_l     <= w_pop;
        r_done  <= 1'b1;
        r_opcnt <= r_opcnt + 16'd1;
      end else if (w_done_clr) begin
        r_done <= 1'b0;
      end
      if (gpio_latch) r_gpio_in_s <= gpio_in;
      if (w_rd_e)     sdata_out   <= w_rd_data;
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[STAT_VALID]    = (r_w[63:32] == 32'd0);
    w_status[STAT_DONE]     = r_done;
    w_status[STAT_BUSY]     = w_busy;
  end

  always_comb begin
    w_rd_data = '0;
    case (saddress)
      ADDR_A1:      w_rd_data = 32'(r_a1);
      ADDR_W_LO:    w_rd_data = r_w[31:0];
      ADDR_L:       w_rd_data = {25'd0, r_l};
      ADDR_STATUS:  w_rd_data = w_status;
      ADDR_W_HI:    w_rd_data = r_w[63:32];
      ADDR_OPCNT:   w_rd_data = {16'd0, r_opcnt};
      ADDR_GPIO_IN: w_rd_data = r_gpio_in_s;
`ifdef GPIOEMU_IRQ_EN
      ADDR_IRQ_CTL: w_rd_data = {31'd0, r_irq_en};
`endif
      default:      w_rd_data = '0;
    endcase
  end

  assign gpio_out       = {16'd0, r_opcnt};
  assign gpio_in_s_insp = r_gpio_in_s;
  assign w_unused       = ^sdata_in;

endmodule
